nms_ctrl_fsm: RTL and testbench

//  Control sequencer for the NMS datapath: walks predictions, drives counter enables/resets, consumes status flags.

---
 rtl/nms_ctrl_fsm_pkg.sv | 18 +
 rtl/nms_ctrl_fsm_counter.sv | 26 ++
 rtl/nms_ctrl_fsm.sv | 159 +++++++++++++++
 tb/tb_nms_ctrl_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/nms_ctrl_fsm_pkg.sv
// Shared state encoding and default sizing for the NMS control sequencer.
package nms_ctrl_fsm_pkg;

  localparam int unsigned IouLatDefault  = 8;
  localparam int unsigned MaxKeptDefault = 1024;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StClear   = 4'd1,
    StFetch   = 4'd2,
    StFill    = 4'd3,
    StCompare = 4'd4,
    StCommit  = 4'd5,
    StNext    = 4'd6,
    StDone    = 4'd7
  } nms_state_e;

endpackage

// File: rtl/nms_ctrl_fsm_counter.sv
// Clearable up-counter used for the kept-box count.
module nms_ctrl_fsm_counter #(
  parameter int unsigned Width = 14
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/nms_ctrl_fsm.sv
// NMS control sequencer: score-gates predictions, sweeps kept boxes through the IoU
// pipeline and commits or drops each candidate.
module nms_ctrl_fsm
  import nms_ctrl_fsm_pkg::*;
#(
  parameter int unsigned BBOX_IND_WIDTH = 14,
  parameter int unsigned MAX_KEPT       = MaxKeptDefault,
  parameter int unsigned IOU_LAT        = IouLatDefault
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [BBOX_IND_WIDTH-1:0] num_kept,
  input  logic                      pred_valid,
  output logic                      pred_ready,
  input  logic                      i_lt_num_pred,
  input  logic                      iter_eq_last,
  input  logic                      iter_eq_lstMinus1,
  input  logic                      delay_eq_8,
  input  logic                      S_under_thresh,
  input  logic                      iou_valid,
  input  logic                      iou_suppress,
  output logic                      gen_rst,
  output logic                      delay_rst,
  output logic                      delay_en,
  output logic                      bbox_iter_rst,
  output logic                      bbox_iter_en,
  output logic                      bbox_last_en,
  output logic                      i_counter_en,
  output logic                      bbox_we
);

  // FILL exits on the datapath's hard-wired delay_eq_8 flag.
  if (IOU_LAT != 8) begin : g_lat_check
    $error("nms_ctrl_fsm: IOU_LAT must be 8 to match delay_eq_8");
  end

  nms_state_e state_q, state_d;
  logic       suppress_q, suppress_d;
  logic       overflow_q, overflow_d;
  logic       kept_clr;
  logic       kept_full;
  logic       kept_empty;

  assign kept_full  = (num_kept >= BBOX_IND_WIDTH'(MAX_KEPT));
  // The iterator only reads as "at last" with an empty set once num_kept is zero.
  assign kept_empty = iter_eq_last & (num_kept == '0);

  always_comb begin
    state_d       = state_q;
    suppress_d    = suppress_q;
    overflow_d    = overflow_q;
    kept_clr      = 1'b0;
    done          = 1'b0;
    pred_ready    = 1'b0;
    gen_rst       = 1'b0;
    delay_rst     = 1'b0;
    delay_en      = 1'b0;
    bbox_iter_rst = 1'b0;
    bbox_iter_en  = 1'b0;
    bbox_last_en  = 1'b0;
    i_counter_en  = 1'b0;
    bbox_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StClear;
          overflow_d = 1'b0;
          kept_clr   = 1'b1;
        end
      end
      StClear: begin
        gen_rst = 1'b1;
        state_d = StFetch;
      end
      StFetch: begin
        if (!i_lt_num_pred) begin
          state_d = StDone;
        end else begin
          pred_ready = 1'b1;
          if (pred_valid) begin
            if (S_under_thresh) begin
              i_counter_en = 1'b1;
            end else if (kept_empty) begin
              state_d = StCommit;
            end else begin
              delay_rst     = 1'b1;
              bbox_iter_rst = 1'b1;
              suppress_d    = 1'b0;
              state_d       = StFill;
            end
          end
        end
      end
      StFill: begin
        delay_en = 1'b1;
        if (delay_eq_8) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (iou_valid) begin
          bbox_iter_en = 1'b1;
          suppress_d   = suppress_q | iou_suppress;
          if (iter_eq_lstMinus1) begin
            state_d = suppress_d ? StNext : StCommit;
          end
        end
      end
      StCommit: begin
        if (!kept_full) begin
          bbox_we      = 1'b1;
          bbox_last_en = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
        state_d = StNext;
      end
      StNext: begin
        i_counter_en = 1'b1;
        state_d      = StFetch;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      suppress_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      suppress_q <= suppress_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign overflow = overflow_q;

  nms_ctrl_fsm_counter #(
    .Width (BBOX_IND_WIDTH)
  ) u_kept_cnt (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clr_i   (kept_clr),
    .en_i    (bbox_we),
    .count_o (num_kept)
  );

endmodule

// File: tb/tb_nms_ctrl_fsm.sv
// Directed bench for nms_ctrl_fsm with a small behavioural model of the datapath counters.
module tb_nms_ctrl_fsm;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy, done, overflow;
  logic [13:0] num_kept;
  logic        pred_valid, pred_ready;
  logic        i_lt_num_pred, iter_eq_last, iter_eq_lstMinus1, delay_eq_8, S_under_thresh;
  logic        iou_valid, iou_suppress;
  logic        gen_rst, delay_rst, delay_en, bbox_iter_rst, bbox_iter_en;
  logic        bbox_last_en, i_counter_en, bbox_we;

  // Datapath model state and per-run stimulus tables.
  logic [3:0]  num_pred;
  logic [15:0] low_mask;
  logic [15:0] supp_tbl [16];
  logic [3:0]  i_q, iter_q, kcnt_q;
  logic [4:0]  dcnt_q;

  int n_gen = 0, n_icnt = 0, n_we = 0, n_we_last = 0, n_last = 0;
  int n_dly = 0, n_iter = 0, n_done = 0;
  int b_gen, b_icnt, b_we, b_we_last, b_last, b_dly, b_iter, b_done;
  int n_chk = 0, n_err = 0;
  int lat;

  always #5 clk = ~clk;

  nms_ctrl_fsm #(
    .BBOX_IND_WIDTH (14),
    .MAX_KEPT       (2),
    .IOU_LAT        (8)
  ) u_dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .num_kept          (num_kept),
    .pred_valid        (pred_valid),
    .pred_ready        (pred_ready),
    .i_lt_num_pred     (i_lt_num_pred),
    .iter_eq_last      (iter_eq_last),
    .iter_eq_lstMinus1 (iter_eq_lstMinus1),
    .delay_eq_8        (delay_eq_8),
    .S_under_thresh    (S_under_thresh),
    .iou_valid         (iou_valid),
    .iou_suppress      (iou_suppress),
    .gen_rst           (gen_rst),
    .delay_rst         (delay_rst),
    .delay_en          (delay_en),
    .bbox_iter_rst     (bbox_iter_rst),
    .bbox_iter_en      (bbox_iter_en),
    .bbox_last_en      (bbox_last_en),
    .i_counter_en      (i_counter_en),
    .bbox_we           (bbox_we)
  );

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_q <= '0; iter_q <= '0; kcnt_q <= '0; dcnt_q <= '0;
    end else if (gen_rst) begin
      i_q <= '0; iter_q <= '0; kcnt_q <= '0; dcnt_q <= '0;
    end else begin
      if (i_counter_en) i_q <= i_q + 4'd1;
      if (delay_rst) dcnt_q <= '0;
      else if (delay_en) dcnt_q <= dcnt_q + 5'd1;
      if (bbox_iter_rst) iter_q <= '0;
      else if (bbox_iter_en) iter_q <= iter_q + 4'd1;
      if (bbox_last_en) kcnt_q <= kcnt_q + 4'd1;
    end
  end

  assign i_lt_num_pred     = (i_q < num_pred);
  assign S_under_thresh    = low_mask[i_q];
  assign delay_eq_8        = (dcnt_q == 5'd7);
  assign iter_eq_last      = (iter_q == kcnt_q);
  assign iter_eq_lstMinus1 = (kcnt_q != 4'd0) && (iter_q == kcnt_q - 4'd1);
  assign iou_suppress      = supp_tbl[i_q][iter_q];

  always @(posedge clk) begin
    if (gen_rst)                 n_gen     <= n_gen + 1;
    if (i_counter_en)            n_icnt    <= n_icnt + 1;
    if (bbox_we)                 n_we      <= n_we + 1;
    if (bbox_we && bbox_last_en) n_we_last <= n_we_last + 1;
    if (bbox_last_en)            n_last    <= n_last + 1;
    if (delay_en)                n_dly     <= n_dly + 1;
    if (bbox_iter_en)            n_iter    <= n_iter + 1;
    if (done)                    n_done    <= n_done + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_gen = n_gen; b_icnt = n_icnt; b_we = n_we; b_we_last = n_we_last;
    b_last = n_last; b_dly = n_dly; b_iter = n_iter; b_done = n_done;
  endtask

  // Pulses start, returns the negedge index (1 = first cycle after start) on which done shows.
  task automatic run(input logic [3:0] np, input int restart_at, output int l);
    num_pred = np;
    snap();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; l = 1;
    while (!done && l < 200) begin
      @(negedge clk); l++;
      start = (l == restart_at);
    end
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; pred_valid = 1'b1; iou_valid = 1'b1;
    num_pred = '0; low_mask = '0;
    for (int k = 0; k < 16; k++) supp_tbl[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_num_kept", 32'(num_kept), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_pred_ready", 32'(pred_ready), 0);
    check("rst_gen_rst", 32'(gen_rst), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Empty prediction list: CLEAR, FETCH, DONE.
    run(4'd0, 0, lat);
    check("empty_latency", 32'(lat), 3);
    check("empty_gen_rst", 32'(n_gen - b_gen), 1);
    check("empty_we", 32'(n_we - b_we), 0);
    check("empty_num_kept", 32'(num_kept), 0);
    check("empty_done_pulses", 32'(n_done - b_done), 1);
    check("empty_idle_busy", 32'(busy), 0);

    // All predictions under threshold.
    low_mask = 16'h0007;
    run(4'd3, 0, lat);
    check("low_latency", 32'(lat), 6);
    check("low_icnt", 32'(n_icnt - b_icnt), 3);
    check("low_we", 32'(n_we - b_we), 0);
    check("low_num_kept", 32'(num_kept), 0);

    // First survivor commits without filling the IoU pipe.
    low_mask = '0;
    run(4'd1, 0, lat);
    check("first_latency", 32'(lat), 6);
    check("first_delay_en", 32'(n_dly - b_dly), 0);
    check("first_we", 32'(n_we - b_we), 1);
    check("first_we_with_last", 32'(n_we_last - b_we_last), 1);
    check("first_num_kept", 32'(num_kept), 1);

    // Two kept, third suppressed by box 0; stray start mid-run must be ignored.
    supp_tbl[2] = 16'h0001;
    run(4'd3, 10, lat);
    check("supp_latency", 32'(lat), 30);
    check("supp_gen_rst", 32'(n_gen - b_gen), 1);
    check("supp_we", 32'(n_we - b_we), 2);
    check("supp_delay_en", 32'(n_dly - b_dly), 16);
    check("supp_iter_en", 32'(n_iter - b_iter), 3);
    check("supp_num_kept", 32'(num_kept), 2);
    check("supp_overflow", 32'(overflow), 0);

    // Third disjoint survivor overflows MAX_KEPT=2.
    supp_tbl[2] = '0;
    run(4'd3, 0, lat);
    check("ovf_latency", 32'(lat), 31);
    check("ovf_we", 32'(n_we - b_we), 2);
    check("ovf_last_en", 32'(n_last - b_last), 2);
    check("ovf_num_kept", 32'(num_kept), 2);
    check("ovf_overflow", 32'(overflow), 1);
    repeat (2) @(negedge clk);
    check("ovf_sticky", 32'(overflow), 1);

    // Stall in COMPARE with iou_valid low, then asynchronous reset.
    iou_valid = 1'b0;
    num_pred  = 4'd2;
    snap();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart_overflow_clr", 32'(overflow), 0);
    check("restart_num_kept_clr", 32'(num_kept), 0);
    for (int c = 2; c <= 16; c++) @(negedge clk);
    check("stall_busy", 32'(busy), 1);
    check("stall_iter_en", 32'(bbox_iter_en), 0);
    check("stall_delay_en", 32'(delay_en), 0);
    check("stall_num_kept", 32'(num_kept), 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_num_kept", 32'(num_kept), 0);
    check("arst_pred_ready", 32'(pred_ready), 0);
    @(negedge clk); resetn = 1'b1;
    check("arst_no_done", 32'(n_done - b_done), 0);

    iou_valid = 1'b1;
    run(4'd1, 0, lat);
    check("post_latency", 32'(lat), 6);
    check("post_gen_rst", 32'(n_gen - b_gen), 1);
    check("post_num_kept", 32'(num_kept), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
